// File: rtl/mul_rebuild_if.sv
// -----------------------------------------------------------------------------
// mul_rebuild_if
// Request/response bundle for the dividend-rebuild unit.
//   start       : operation request, honoured only while busy is low
//   i_shang     : quotient (multiplier), size bits
//   i_divisor   : divisor (multiplicand), size bits
//   i_yushu     : remainder (addend), size bits
//   busy        : operation in progress
//   done        : one-cycle pulse when o_dividend / o_err update
//   o_dividend  : rebuilt dividend, 2*size bits, held until the next done
//   o_err       : inconsistent triple (divisor==0 or yushu>=divisor)
// The master modport is the requester; the slave modport is the unit.
// -----------------------------------------------------------------------------
interface mul_rebuild_if #(
    parameter int size = 4
);
    logic                  start;
    logic [size-1:0]       i_shang;
    logic [size-1:0]       i_divisor;
    logic [size-1:0]       i_yushu;
    logic                  busy;
    logic                  done;
    logic [2*size-1:0]     o_dividend;
    logic                  o_err;

    modport master (
        output start, i_shang, i_divisor, i_yushu,
        input  busy, done, o_dividend, o_err
    );

    modport slave (
        input  start, i_shang, i_divisor, i_yushu,
        output busy, done, o_dividend, o_err
    );
endinterface

// File: rtl/mul_rebuild.sv
// -----------------------------------------------------------------------------
// mul_rebuild
// Sequential shift-add multiply-accumulate that rebuilds a dividend from a
// division result: o_dividend = i_shang * i_divisor + i_yushu (unsigned).
// One multiplier bit is consumed per clock, so an operation takes size cycles
// after the accept edge. A divisor of zero or a remainder not below the
// divisor raises o_err; the result is still computed.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mul_rebuild_if.slave (start/busy/done handshake, operands, result)
// -----------------------------------------------------------------------------
module mul_rebuild #(
    parameter int size = 4
) (
    input  logic           clk,
    input  logic           rst,
    mul_rebuild_if.slave   bus
);
    localparam int CNT_W = $clog2(size) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    state_t                  state_n;

    logic [2*size-1:0]       acc;
    logic [2*size-1:0]       mcand;
    logic [size-1:0]         mplier;
    logic [CNT_W-1:0]        cnt;
    logic                    err_r;

    logic                    busy_r;
    logic                    done_r;
    logic [2*size-1:0]       dividend_r;
    logic                    err_out_r;

    logic                    load;
    logic                    finish;
    logic [2*size-1:0]       acc_sum;

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.o_dividend = dividend_r;
    assign bus.o_err      = err_out_r;

    // Conditional add for the current multiplier bit; the final result must
    // include the add of the last step, so it is taken from here, not acc.
    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(size - 1)) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dividend_r <= '0;
            err_out_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (load) begin
                acc    <= {{size{1'b0}}, bus.i_yushu};
                mcand  <= {{size{1'b0}}, bus.i_divisor};
                mplier <= bus.i_shang;
                cnt    <= '0;
                err_r  <= (bus.i_divisor == '0) | (bus.i_yushu >= bus.i_divisor);
                busy_r <= 1'b1;
            end else if (state == RUN) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (finish) begin
                    dividend_r <= acc_sum;
                    err_out_r  <= err_r;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_rebuild.sv
// -----------------------------------------------------------------------------
// tb_mul_rebuild
// Directed bench for mul_rebuild with size=4. Each scenario task drives its
// own stimulus and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mul_rebuild;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mul_rebuild_if #(.size(4)) bus ();

    mul_rebuild #(.size(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for its done pulse.
    task automatic run_op(input logic [3:0] s, input logic [3:0] d, input logic [3:0] y,
                          output int lat, output logic [7:0] div, output logic err,
                          output logic bsy);
        @(negedge clk);
        bus.i_shang   = s;
        bus.i_divisor = d;
        bus.i_yushu   = y;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        div = 'x;
        err = 1'bx;
        bsy = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                div = bus.o_dividend;
                err = bus.o_err;
                bsy = bus.busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_tests++; if (bus.o_dividend !== 8'd0) begin n_fail++; $display("FAIL reset_dividend got=%0d exp=0", bus.o_dividend); end
        n_tests++; if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.o_err); end
        // rst and start together: nothing accepted
        bus.i_shang = 4'd1; bus.i_divisor = 4'd5; bus.i_yushu = 4'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_basic();
        int lat; logic [7:0] div; logic err; logic bsy;
        @(negedge clk);
        bus.i_shang = 4'd1; bus.i_divisor = 4'd5; bus.i_yushu = 4'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_accept got=%b exp=1", bus.busy); end
        lat = -1; div = 'x; err = 1'bx; bsy = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c; div = bus.o_dividend; err = bus.o_err; bsy = bus.busy;
                break;
            end
        end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        n_tests++; if (div !== 8'd8) begin n_fail++; $display("FAIL basic_dividend got=%0d exp=8", div); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b exp=0", err); end
        n_tests++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got=%b exp=0", bsy); end
        @(posedge clk);
        #1;
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle got=%b exp=0", bus.done); end
        n_tests++; if (bus.o_dividend !== 8'd8) begin n_fail++; $display("FAIL basic_hold got=%0d exp=8", bus.o_dividend); end
    endtask

    task automatic test_patterns();
        int lat; logic [7:0] div; logic err; logic bsy;
        run_op(4'd2, 4'd4, 4'd0, lat, div, err, bsy);
        n_tests++; if (div !== 8'd8 || err !== 1'b0) begin n_fail++; $display("FAIL pat_2_4_0 got=%0d/%b exp=8/0", div, err); end
        run_op(4'd2, 4'd3, 4'd2, lat, div, err, bsy);
        n_tests++; if (div !== 8'd8 || err !== 1'b0) begin n_fail++; $display("FAIL pat_2_3_2 got=%0d/%b exp=8/0", div, err); end
        run_op(4'd6, 4'd9, 4'd4, lat, div, err, bsy);
        n_tests++; if (div !== 8'd58 || err !== 1'b0) begin n_fail++; $display("FAIL pat_6_9_4 got=%0d/%b exp=58/0", div, err); end
    endtask

    task automatic test_extremes();
        int lat; logic [7:0] div; logic err; logic bsy;
        run_op(4'd15, 4'd15, 4'd14, lat, div, err, bsy);
        n_tests++; if (div !== 8'd239 || err !== 1'b0) begin n_fail++; $display("FAIL ext_max got=%0d/%b exp=239/0", div, err); end
        run_op(4'd0, 4'd7, 4'd6, lat, div, err, bsy);
        n_tests++; if (div !== 8'd6) begin n_fail++; $display("FAIL ext_zero_shang got=%0d exp=6", div); end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL ext_zero_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_err();
        int lat; logic [7:0] div; logic err; logic bsy;
        run_op(4'd9, 4'd0, 4'd5, lat, div, err, bsy);
        n_tests++; if (div !== 8'd5) begin n_fail++; $display("FAIL err_div0_val got=%0d exp=5", div); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_div0_flag got=%b exp=1", err); end
        run_op(4'd1, 4'd3, 4'd3, lat, div, err, bsy);
        n_tests++; if (div !== 8'd6) begin n_fail++; $display("FAIL err_rem_val got=%0d exp=6", div); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_rem_flag got=%b exp=1", err); end
        run_op(4'd1, 4'd4, 4'd3, lat, div, err, bsy);
        n_tests++; if (div !== 8'd7 || err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%0d/%b exp=7/0", div, err); end
    endtask

    task automatic test_ignore_start();
        int dones; logic [7:0] first;
        dones = 0; first = 'x;
        @(negedge clk);
        bus.i_shang = 4'd3; bus.i_divisor = 4'd5; bus.i_yushu = 4'd1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        // second request mid-run with different operands
        bus.i_shang = 4'd15; bus.i_divisor = 4'd15; bus.i_yushu = 4'd0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (bus.done) begin dones++; first = bus.o_dividend; end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                if (dones == 1) first = bus.o_dividend;
            end
        end
        n_tests++; if (first !== 8'd16) begin n_fail++; $display("FAIL ignore_result got=%0d exp=16", first); end
        n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
        n_tests++; if (bus.o_dividend !== 8'd16) begin n_fail++; $display("FAIL ignore_hold got=%0d exp=16", bus.o_dividend); end
    endtask

    task automatic test_back_to_back();
        int dones; int last_c; int bad_gap; int bad_val;
        dones = 0; last_c = -1; bad_gap = 0; bad_val = 0;
        @(negedge clk);
        bus.i_shang = 4'd2; bus.i_divisor = 4'd7; bus.i_yushu = 4'd1;
        bus.start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                if (last_c >= 0 && (c - last_c) != 5) bad_gap++;
                last_c = c;
            end
            if (dones > 0 && bus.o_dividend !== 8'd15) bad_val++;
        end
        bus.start = 1'b0;
        n_tests++; if (dones !== 3) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=3", dones); end
        n_tests++; if (bad_gap !== 0) begin n_fail++; $display("FAIL b2b_period bad_gaps=%0d exp=0", bad_gap); end
        n_tests++; if (bad_val !== 0) begin n_fail++; $display("FAIL b2b_stable bad_cycles=%0d exp=0", bad_val); end
        n_tests++; if (last_c !== 15) begin n_fail++; $display("FAIL b2b_last_done got=%0d exp=15", last_c); end
        for (int c = 0; c < 10 && bus.busy; c++) begin
            @(posedge clk);
            #1;
        end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int dones; int lat; logic [7:0] div; logic err; logic bsy;
        dones = 0;
        @(negedge clk);
        bus.i_shang = 4'd15; bus.i_divisor = 4'd15; bus.i_yushu = 4'd0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        n_tests++; if (bus.o_dividend !== 8'd0) begin n_fail++; $display("FAIL rstmid_dividend got=%0d exp=0", bus.o_dividend); end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
        run_op(4'd3, 4'd5, 4'd2, lat, div, err, bsy);
        n_tests++; if (div !== 8'd17) begin n_fail++; $display("FAIL rstmid_next got=%0d exp=17", div); end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL rstmid_next_latency got=%0d exp=4", lat); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.i_shang = '0;
        bus.i_divisor = '0;
        bus.i_yushu = '0;
        test_reset();
        test_basic();
        test_patterns();
        test_extremes();
        test_err();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
